// File: rtl/rtl_settings_pkg.sv
// rtl/rtl_settings_pkg.sv - shared widths, enums and the compare-entry struct
package rtl_settings_pkg;

    // Avalon-MM data path: 512-bit words, 64 bytes per word.
    localparam int AMM_DATA_W  = 512;
    localparam int AMM_BURST_W = 11;
    localparam int ADDR_W      = 32;
    localparam int ADDR_B_W    = $clog2(AMM_DATA_W / 8);
    localparam int CMP_ADDR_W  = ADDR_W - ADDR_B_W;

    typedef enum logic [1:0] {
        DM_FIXED = 2'd0,
        DM_INCR  = 2'd1,
        DM_LFSR  = 2'd2,
        DM_ZERO  = 2'd3
    } data_mode_t;

    typedef enum logic [1:0] {
        IDLE_S = 2'd0,
        CALC_S = 2'd1,
        EMIT_S = 2'd2
    } gen_state_t;

    // One compare entry: a run of consecutive words with byte offsets
    // trimming the first and last word.
    typedef struct packed {
        logic                   trans_type;
        data_mode_t             data_mode;
        logic [7:0]             data_ptrn;
        logic [CMP_ADDR_W-1:0]  start_addr;
        logic [ADDR_B_W-1:0]    start_off;
        logic [ADDR_B_W-1:0]    end_off;
        logic [AMM_BURST_W-1:0] words_count;
    } cmp_struct_t;

endpackage

// File: rtl/cmp_cmd_gen_if.sv
// rtl/cmp_cmd_gen_if.sv - transaction request and compare-entry bundle
//
// Groups the request handshake and the compare-entry handshake of
// cmp_cmd_gen. master = transaction source / entry consumer,
// slave = the command generator.
interface cmp_cmd_gen_if #(
    parameter int LEN_W = 32
);
    import rtl_settings_pkg::*;

    logic              trans_valid;
    logic              trans_ready;
    logic [ADDR_W-1:0] trans_addr;
    logic [LEN_W-1:0]  trans_len;
    logic              trans_type;
    data_mode_t        data_mode;
    logic [7:0]        data_ptrn;
    logic              cmp_valid;
    logic              cmp_ready;
    cmp_struct_t       cmp;
    logic              busy;

    modport master (
        output trans_valid, trans_addr, trans_len, trans_type, data_mode, data_ptrn,
        output cmp_ready,
        input  trans_ready, cmp_valid, cmp, busy
    );

    modport slave (
        input  trans_valid, trans_addr, trans_len, trans_type, data_mode, data_ptrn,
        input  cmp_ready,
        output trans_ready, cmp_valid, cmp, busy
    );

endinterface

// File: rtl/cmp_cmd_gen.sv
// rtl/cmp_cmd_gen.sv - splits a byte-range transaction into compare entries
//
// Ports:
//   clk_i, rst_n_i         clock, asynchronous active-low reset
//   trans_*_i / trans_ready_o, data_mode_i, data_ptrn_i
//                          transaction request (byte address, length-1)
//   cmp_valid_o / cmp_ready_i / cmp_o
//                          compare-entry stream, at most MAX_WORDS words each
//   busy_o                 high whenever the FSM is not idle
//   entry_cnt_o            saturating count of accepted entries, present only
//                          when CMP_CMD_GEN_STAT_EN is defined
module cmp_cmd_gen
    import rtl_settings_pkg::*;
#(
    parameter int LEN_W     = 32,
    parameter int MAX_WORDS = 2 ** (AMM_BURST_W - 1)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              trans_valid_i,
    output logic              trans_ready_o,
    input  logic [ADDR_W-1:0] trans_addr_i,
    input  logic [LEN_W-1:0]  trans_len_i,
    input  logic              trans_type_i,
    input  data_mode_t        data_mode_i,
    input  logic [7:0]        data_ptrn_i,
    output logic              cmp_valid_o,
    input  logic              cmp_ready_i,
    output cmp_struct_t       cmp_o,
    output logic              busy_o
`ifdef CMP_CMD_GEN_STAT_EN
    ,
    output logic [31:0]       entry_cnt_o
`endif
);

    localparam logic [CMP_ADDR_W:0] MAX_W   = (CMP_ADDR_W + 1)'(MAX_WORDS);
    localparam logic [CMP_ADDR_W:0] ONE_W   = (CMP_ADDR_W + 1)'(1);

    gen_state_t            state;
    logic [ADDR_W-1:0]     addr_r;
    logic [LEN_W-1:0]      len_r;
    logic                  type_r;
    data_mode_t            mode_r;
    logic [7:0]            ptrn_r;
    logic [CMP_ADDR_W-1:0] next_addr;
    logic [CMP_ADDR_W:0]   remaining;
    logic                  first_r;
    logic [ADDR_B_W-1:0]   start_off_r;
    logic [ADDR_B_W-1:0]   end_off_r;

    logic [ADDR_W-1:0]     end_byte;
    logic [CMP_ADDR_W-1:0] word_span;
    logic [CMP_ADDR_W:0]   words_c;
    logic                  last_c;
    cmp_struct_t           entry_c;

    assign trans_ready_o = (state == IDLE_S);
    assign busy_o        = (state != IDLE_S);

    // Address arithmetic wraps naturally at the register widths, so a
    // transaction crossing the top of the address space needs no special case.
    always_comb begin
        end_byte  = addr_r + ADDR_W'(len_r);
        word_span = end_byte[ADDR_W-1:ADDR_B_W] - addr_r[ADDR_W-1:ADDR_B_W];
    end

    // Next entry built from the running state; it is valid to present
    // whenever remaining is non-zero.
    always_comb begin
        last_c              = (remaining <= MAX_W);
        words_c             = last_c ? remaining : MAX_W;
        entry_c             = '0;
        entry_c.trans_type  = type_r;
        entry_c.data_mode   = mode_r;
        entry_c.data_ptrn   = ptrn_r;
        entry_c.start_addr  = next_addr;
        entry_c.start_off   = first_r ? start_off_r : '0;
        entry_c.end_off     = last_c ? end_off_r : '1;
        entry_c.words_count = AMM_BURST_W'(words_c - ONE_W);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE_S;
            addr_r      <= '0;
            len_r       <= '0;
            type_r      <= 1'b0;
            mode_r      <= DM_FIXED;
            ptrn_r      <= '0;
            next_addr   <= '0;
            remaining   <= '0;
            first_r     <= 1'b0;
            start_off_r <= '0;
            end_off_r   <= '0;
            cmp_valid_o <= 1'b0;
            cmp_o       <= '0;
        end else begin
            case (state)
                IDLE_S: begin
                    if (trans_valid_i) begin
                        addr_r <= trans_addr_i;
                        len_r  <= trans_len_i;
                        type_r <= trans_type_i;
                        mode_r <= data_mode_i;
                        ptrn_r <= data_ptrn_i;
                        state  <= CALC_S;
                    end
                end
                CALC_S: begin
                    next_addr   <= addr_r[ADDR_W-1:ADDR_B_W];
                    start_off_r <= addr_r[ADDR_B_W-1:0];
                    end_off_r   <= end_byte[ADDR_B_W-1:0];
                    remaining   <= {1'b0, word_span} + ONE_W;
                    first_r     <= 1'b1;
                    state       <= EMIT_S;
                end
                EMIT_S: begin
                    // First cycle in EMIT loads entry one; afterwards each
                    // handshake either loads the next entry (no bubble) or,
                    // with nothing left, closes out the transaction.
                    if (!cmp_valid_o || cmp_ready_i) begin
                        if (remaining != '0) begin
                            cmp_o       <= entry_c;
                            cmp_valid_o <= 1'b1;
                            next_addr   <= next_addr + CMP_ADDR_W'(words_c);
                            remaining   <= remaining - words_c;
                            first_r     <= 1'b0;
                        end else begin
                            cmp_valid_o <= 1'b0;
                            state       <= IDLE_S;
                        end
                    end
                end
                default: begin
                    cmp_valid_o <= 1'b0;
                    state       <= IDLE_S;
                end
            endcase
        end
    end

`ifdef CMP_CMD_GEN_STAT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            entry_cnt_o <= '0;
        end else if (cmp_valid_o && cmp_ready_i && (entry_cnt_o != '1)) begin
            entry_cnt_o <= entry_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cmp_cmd_gen.sv
// tb/tb_cmp_cmd_gen.sv - scoreboard bench for cmp_cmd_gen
module tb_cmp_cmd_gen;
    import rtl_settings_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    int   hs_count;
    cmp_struct_t sb_q[$];

    cmp_cmd_gen_if #(.LEN_W(32)) bus ();

`ifdef CMP_CMD_GEN_STAT_EN
    logic [31:0] entry_cnt;
`endif

    cmp_cmd_gen #(.LEN_W(32), .MAX_WORDS(1024)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .trans_valid_i (bus.trans_valid),
        .trans_ready_o (bus.trans_ready),
        .trans_addr_i  (bus.trans_addr),
        .trans_len_i   (bus.trans_len),
        .trans_type_i  (bus.trans_type),
        .data_mode_i   (bus.data_mode),
        .data_ptrn_i   (bus.data_ptrn),
        .cmp_valid_o   (bus.cmp_valid),
        .cmp_ready_i   (bus.cmp_ready),
        .cmp_o         (bus.cmp),
        .busy_o        (bus.busy)
`ifdef CMP_CMD_GEN_STAT_EN
        ,
        .entry_cnt_o   (entry_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: 64-byte words, 1024 words per entry, 26-bit word address.
    function automatic void push_model(input logic [31:0] a, input logic [31:0] l,
                                       input logic t, input data_mode_t m,
                                       input logic [7:0] p, input int max_entries);
        logic [31:0]     eb;
        longint unsigned sw, ew, total, words, idx;
        cmp_struct_t     e;
        eb    = a + l;
        sw    = longint'(a >> 6);
        ew    = longint'(eb >> 6);
        total = ((ew - sw) & 64'h3FF_FFFF) + 1;
        idx   = 0;
        while (total > 0 && idx < longint'(max_entries)) begin
            words         = (total > 1024) ? 1024 : total;
            e             = '0;
            e.trans_type  = t;
            e.data_mode   = m;
            e.data_ptrn   = p;
            e.start_addr  = 26'((sw + idx * 1024) & 64'h3FF_FFFF);
            e.start_off   = (idx == 0) ? a[5:0] : 6'd0;
            e.end_off     = (total == words) ? eb[5:0] : 6'h3F;
            e.words_count = 11'(words - 1);
            sb_q.push_back(e);
            total -= words;
            idx++;
        end
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] l, input logic t,
                        input data_mode_t m, input logic [7:0] p, input int max_entries);
        int budget;
        budget = 200;
        @(negedge clk);
        while (bus.trans_ready !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: trans_ready=%b required 1", bus.trans_ready);
        end
        bus.trans_addr  = a;
        bus.trans_len   = l;
        bus.trans_type  = t;
        bus.data_mode   = m;
        bus.data_ptrn   = p;
        bus.trans_valid = 1'b1;
        push_model(a, l, t, m, p, max_entries);
        @(posedge clk);
        #1 bus.trans_valid = 1'b0;
    endtask

    // Consume entries, comparing cmp every valid cycle (so held entries are
    // checked for stability) and popping only on a handshake.
    task automatic drain(input int stall_cycles, input bit rand_ready, input int max_pops);
        int budget, stall, pops;
        bit prev_hs, rdy;
        budget  = 5000;
        stall   = stall_cycles;
        pops    = 0;
        prev_hs = 1'b0;
        while (sb_q.size() > 0 && pops < max_pops && budget > 0) begin
            @(negedge clk);
            budget--;
            if (stall > 0 && bus.cmp_valid === 1'b1) begin
                rdy = 1'b0;
                stall--;
            end else begin
                rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            bus.cmp_ready = rdy;
            if (prev_hs) begin
                vectors++;
                if (bus.cmp_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL no_bubble: cmp_valid=%b required 1", bus.cmp_valid);
                end
            end
            prev_hs = 1'b0;
            if (bus.cmp_valid === 1'b1) begin
                vectors++;
                if (bus.cmp !== sb_q[0]) begin
                    miscompares++;
                    $display("FAIL entry: got %h required %h", bus.cmp, sb_q[0]);
                end
                if (rdy) begin
                    void'(sb_q.pop_front());
                    prev_hs = 1'b1;
                    pops++;
                    hs_count++;
                end
            end
        end
        if (budget == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d entries left, required 0", sb_q.size());
        end
        if (sb_q.size() == 0) begin
            @(negedge clk);
            bus.cmp_ready = 1'b0;
            vectors++;
            if (bus.cmp_valid !== 1'b0 || bus.trans_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL end_idle: cmp_valid=%b trans_ready=%b required 0 1",
                         bus.cmp_valid, bus.trans_ready);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.cmp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid_busy: %b %b required 0 0", bus.cmp_valid, bus.busy);
        end
        vectors++;
        if (bus.trans_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: %b required 1", bus.trans_ready);
        end
        vectors++;
        if (bus.cmp !== cmp_struct_t'('0)) begin
            miscompares++;
            $display("FAIL reset_cmp: %h required 0", bus.cmp);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        send(32'h05, 32'd2, 1'b1, DM_INCR, 8'hA5, 16);
        @(negedge clk);
        vectors++;
        if (bus.cmp_valid !== 1'b0 || bus.busy !== 1'b1 || bus.trans_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL calc_state: valid=%b busy=%b ready=%b required 0 1 0",
                     bus.cmp_valid, bus.busy, bus.trans_ready);
        end
        @(negedge clk);
        vectors++;
        if (bus.cmp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_early: cmp_valid=%b required 0", bus.cmp_valid);
        end
        @(negedge clk);
        vectors++;
        if (bus.cmp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL latency_2: cmp_valid=%b required 1", bus.cmp_valid);
        end
        drain(0, 1'b0, 1000);
    endtask

    task automatic test_offset();
        send(32'h3F, 32'd1, 1'b0, DM_FIXED, 8'h3C, 16);
        drain(0, 1'b0, 1000);
    endtask

    task automatic test_split_stall();
        send(32'h0, 32'd65599, 1'b1, DM_LFSR, 8'h11, 16);
        drain(5, 1'b0, 1000);
    endtask

    task automatic test_wrap();
        send(32'hFFFF_FFC0, 32'd65599, 1'b0, DM_ZERO, 8'hFE, 16);
        drain(0, 1'b0, 1000);
    endtask

    task automatic test_reset_mid();
        send(32'h40, 32'hFFFF_FFFF, 1'b1, DM_INCR, 8'h77, 4);
        drain(0, 1'b0, 1);
        @(negedge clk);
        bus.cmp_ready = 1'b0;
        vectors++;
        if (bus.cmp_valid !== 1'b1 || bus.cmp !== sb_q[0]) begin
            miscompares++;
            $display("FAIL entry2_pre_reset: valid=%b cmp=%h required 1 %h",
                     bus.cmp_valid, bus.cmp, sb_q[0]);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.cmp_valid !== 1'b0 || bus.trans_ready !== 1'b1 || bus.busy !== 1'b0
            || bus.cmp !== cmp_struct_t'('0)) begin
            miscompares++;
            $display("FAIL mid_reset: valid=%b ready=%b busy=%b cmp=%h required 0 1 0 0",
                     bus.cmp_valid, bus.trans_ready, bus.busy, bus.cmp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        hs_count = 0;
        bus.cmp_ready = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.cmp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL no_reissue: valid=%b busy=%b required 0 0", bus.cmp_valid, bus.busy);
        end
        bus.cmp_ready = 1'b0;
        send(32'h1234_5605, 32'd130, 1'b0, DM_FIXED, 8'h5A, 16);
        drain(0, 1'b0, 1000);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            send($urandom, 32'($urandom_range(0, 200000)), 1'($urandom_range(0, 1)),
                 data_mode_t'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 16);
            drain(0, 1'b1, 1000);
        end
`ifdef CMP_CMD_GEN_STAT_EN
        vectors++;
        if (entry_cnt !== 32'(hs_count)) begin
            miscompares++;
            $display("FAIL entry_cnt: got %0d required %0d", entry_cnt, hs_count);
        end
`endif
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        hs_count        = 0;
        rst_n           = 1'b0;
        bus.trans_valid = 1'b0;
        bus.trans_addr  = '0;
        bus.trans_len   = '0;
        bus.trans_type  = 1'b0;
        bus.data_mode   = DM_FIXED;
        bus.data_ptrn   = '0;
        bus.cmp_ready   = 1'b0;
        test_reset();
        test_single();
        test_offset();
        test_split_stall();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
